// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor: receive-side checker for the DE10-Lite 800x600 VGA output.
// Recovers pixel position from looped-back sync pins, measures line/frame
// timing, declares lock and counts active pixels that differ from EXP_RGB.
module vga_sync_monitor #(
   parameter int unsigned H_TOTAL     = 1040,
   parameter int unsigned H_PULSE     = 120,
   parameter int unsigned H_BACK      = 64,
   parameter int unsigned H_ACTIVE    = 800,
   parameter int unsigned V_TOTAL     = 666,
   parameter int unsigned V_PULSE     = 6,
   parameter int unsigned V_BACK      = 23,
   parameter int unsigned V_ACTIVE    = 600,
   parameter logic        HS_POL      = 1'b1,
   parameter logic        VS_POL      = 1'b1,
   parameter logic [11:0] EXP_RGB     = 12'hF00,
   parameter int unsigned LOCK_FRAMES = 2
) (
   input  logic        MAX10_CLK1_50,
   input  logic        reset_n,
   input  logic        vga_hs,
   input  logic        vga_vs,
   input  logic [3:0]  vga_r,
   input  logic [3:0]  vga_g,
   input  logic [3:0]  vga_b,
   output logic        locked,
   output logic [10:0] pix_x,
   output logic [9:0]  pix_y,
   output logic        pix_de,
   output logic [11:0] pix_rgb,
   output logic [10:0] line_period,
   output logic [10:0] hs_width,
   output logic [9:0]  frame_lines,
   output logic [15:0] frame_err_count,
   output logic        frame_done
);

   localparam int unsigned HW  = 11;
   localparam int unsigned VW  = 10;
   localparam int unsigned EW  = 16;
   localparam int unsigned SW  = 14;
   localparam int unsigned VPW = 4;
   localparam int unsigned MW  = 4;

   localparam logic [HW-1:0]  H_MAX       = '1;
   localparam logic [VW-1:0]  V_MAX       = '1;
   localparam logic [EW-1:0]  E_MAX       = '1;
   localparam logic [VPW-1:0] VP_MAX      = '1;
   localparam logic [HW-1:0]  H_ACT_START = HW'(H_PULSE + H_BACK);
   localparam logic [HW-1:0]  H_ACT_END   = HW'(H_PULSE + H_BACK + H_ACTIVE - 1);
   localparam logic [VW-1:0]  V_ACT_START = VW'(V_PULSE + V_BACK);
   localparam logic [VW-1:0]  V_ACT_END   = VW'(V_PULSE + V_BACK + V_ACTIVE - 1);
   localparam logic [HW-1:0]  H_TOTAL_W   = HW'(H_TOTAL);
   localparam logic [HW-1:0]  H_PULSE_W   = HW'(H_PULSE);
   localparam logic [VW-1:0]  V_TOTAL_W   = VW'(V_TOTAL);
   localparam logic [VPW-1:0] V_PULSE_W   = VPW'(V_PULSE);
   localparam logic [MW-1:0]  LOCK_N      = MW'(LOCK_FRAMES);
   localparam logic [SW-1:0]  SYNC_IDLE   = {~HS_POL, ~VS_POL, 12'h000};

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      CHECK  = 2'd1,
      LOCKED = 2'd2
   } state_t;

   // synchroniser and edge-register stages
   logic [SW-1:0]  sync1;
   logic [SW-1:0]  sync2;
   logic           hs_q;
   logic           vs_q;

   // position counters and measurement state
   logic [HW-1:0]  hcnt;
   logic [VW-1:0]  vcnt;
   logic           seen_hs;
   logic [VPW-1:0] vs_lines;
   logic           mismatch;
   logic [EW-1:0]  err_work;

   state_t         state;
   logic [MW-1:0]  match_cnt;

   // combinational next-state / event terms
   logic           hs_now;
   logic           vs_now;
   logic           hs_lead;
   logic           hs_trail;
   logic           vs_lead;
   logic           vs_trail;
   logic [11:0]    rgb_s;
   logic [HW-1:0]  hcnt_inc;
   logic [HW-1:0]  hcnt_nxt;
   logic [VW-1:0]  vcnt_nxt;
   logic [VW-1:0]  fl_meas;
   logic [VPW-1:0] vs_lines_nxt;
   logic           de_nxt;
   logic           lp_bad;
   logic           hw_bad;
   logic           vsw_bad;
   logic           hs_lost;
   logic           frame_ok;
   logic           mismatch_nxt;

   // edge detection, counter next values and per-cycle timing checks
   always_comb begin
      hs_now       = (sync2[13] == HS_POL);
      vs_now       = (sync2[12] == VS_POL);
      hs_lead      = hs_now & ~hs_q;
      hs_trail     = ~hs_now & hs_q;
      vs_lead      = vs_now & ~vs_q;
      vs_trail     = ~vs_now & vs_q;
      rgb_s        = sync2[11:0];
      hcnt_inc     = hcnt + HW'(1);
      hcnt_nxt     = hcnt;
      vcnt_nxt     = vcnt;
      vs_lines_nxt = vs_lines;

      if (hs_lead) begin
         hcnt_nxt = '0;
      end else if (hcnt != H_MAX) begin
         hcnt_nxt = hcnt_inc;
      end

      // a VS leading edge wins over a coincident HS edge
      if (vs_lead) begin
         vcnt_nxt = '0;
      end else if (hs_lead && (vcnt != V_MAX)) begin
         vcnt_nxt = vcnt + VW'(1);
      end

      fl_meas = hs_lead ? (vcnt + VW'(1)) : vcnt;

      // VS pulse length in HS edges, counting the edge that opens the pulse
      if (vs_lead) begin
         vs_lines_nxt = hs_lead ? VPW'(1) : VPW'(0);
      end else if (vs_now && hs_lead && (vs_lines != VP_MAX)) begin
         vs_lines_nxt = vs_lines + VPW'(1);
      end

      de_nxt = (hcnt_nxt >= H_ACT_START) && (hcnt_nxt <= H_ACT_END) &&
               (vcnt_nxt >= V_ACT_START) && (vcnt_nxt <= V_ACT_END);

      lp_bad   = hs_lead && seen_hs && (hcnt_inc != H_TOTAL_W);
      hw_bad   = hs_trail && (hcnt_inc != H_PULSE_W);
      vsw_bad  = vs_trail && (vs_lines != V_PULSE_W);
      hs_lost  = (hcnt == H_MAX);

      frame_ok = (fl_meas == V_TOTAL_W) &&
                 !(mismatch || lp_bad || hw_bad || vsw_bad || hs_lost);

      if (vs_lead) begin
         mismatch_nxt = 1'b0;
      end else begin
         mismatch_nxt = mismatch || lp_bad || hw_bad || vsw_bad || hs_lost;
      end
   end

   // two-flop synchroniser followed by the edge register
   always_ff @(posedge MAX10_CLK1_50) begin
      if (!reset_n) begin
         sync1 <= SYNC_IDLE;
         sync2 <= SYNC_IDLE;
         hs_q  <= 1'b0;
         vs_q  <= 1'b0;
      end else begin
         sync1 <= {vga_hs, vga_vs, vga_r, vga_g, vga_b};
         sync2 <= sync1;
         hs_q  <= hs_now;
         vs_q  <= vs_now;
      end
   end

   // position counters and line measurements
   always_ff @(posedge MAX10_CLK1_50) begin
      if (!reset_n) begin
         hcnt        <= '0;
         vcnt        <= '0;
         seen_hs     <= 1'b0;
         line_period <= '0;
         hs_width    <= '0;
         vs_lines    <= '0;
         mismatch    <= 1'b0;
      end else begin
         hcnt     <= hcnt_nxt;
         vcnt     <= vcnt_nxt;
         vs_lines <= vs_lines_nxt;
         mismatch <= mismatch_nxt;
         if (hs_lead) begin
            seen_hs <= 1'b1;
            if (seen_hs) begin
               line_period <= hcnt_inc;
            end
         end
         if (hs_trail) begin
            hs_width <= hcnt_inc;
         end
      end
   end

   // aligned pixel outputs
   always_ff @(posedge MAX10_CLK1_50) begin
      if (!reset_n) begin
         pix_de  <= 1'b0;
         pix_x   <= '0;
         pix_y   <= '0;
         pix_rgb <= '0;
      end else begin
         pix_de  <= de_nxt;
         pix_x   <= de_nxt ? (hcnt_nxt - H_ACT_START) : '0;
         pix_y   <= de_nxt ? (vcnt_nxt - V_ACT_START) : '0;
         pix_rgb <= rgb_s;
      end
   end

   // per-frame results and saturating colour error count
   always_ff @(posedge MAX10_CLK1_50) begin
      if (!reset_n) begin
         frame_done      <= 1'b0;
         frame_lines     <= '0;
         frame_err_count <= '0;
         err_work        <= '0;
      end else begin
         frame_done <= vs_lead;
         if (vs_lead) begin
            frame_lines     <= fl_meas;
            frame_err_count <= err_work;
            err_work        <= '0;
         end else if (de_nxt && (rgb_s != EXP_RGB) && (err_work != E_MAX)) begin
            err_work <= err_work + EW'(1);
         end
      end
   end

   // lock FSM: first VS edge, then LOCK_FRAMES matching frames
   always_ff @(posedge MAX10_CLK1_50) begin
      if (!reset_n) begin
         state     <= SEARCH;
         match_cnt <= '0;
         locked    <= 1'b0;
      end else begin
         case (state)
            SEARCH: begin
               locked <= 1'b0;
               if (vs_lead) begin
                  state     <= CHECK;
                  match_cnt <= '0;
               end
            end
            CHECK: begin
               locked <= 1'b0;
               if (vs_lead) begin
                  if (frame_ok) begin
                     match_cnt <= match_cnt + MW'(1);
                     if ((match_cnt + MW'(1)) >= LOCK_N) begin
                        state  <= LOCKED;
                        locked <= 1'b1;
                     end
                  end else begin
                     state <= SEARCH;
                  end
               end
            end
            LOCKED: begin
               if (lp_bad || hw_bad || hs_lost || (vs_lead && !frame_ok)) begin
                  state  <= SEARCH;
                  locked <= 1'b0;
               end else begin
                  locked <= 1'b1;
               end
            end
            default: begin
               state  <= SEARCH;
               locked <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed bench for vga_sync_monitor using a scaled-down video timing.
module tb_vga_sync_monitor;

   localparam int HT = 40;
   localparam int HP = 6;
   localparam int HB = 4;
   localparam int HA = 24;
   localparam int VT = 20;
   localparam int VP = 2;
   localparam int VB = 3;
   localparam int VA = 12;
   localparam int BAD_X = 7;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        vga_hs, vga_vs;
   logic [3:0]  vga_r, vga_g, vga_b;
   logic        locked;
   logic [10:0] pix_x;
   logic [9:0]  pix_y;
   logic        pix_de;
   logic [11:0] pix_rgb;
   logic [10:0] line_period;
   logic [10:0] hs_width;
   logic [9:0]  frame_lines;
   logic [15:0] frame_err_count;
   logic        frame_done;

   always #10 clk = ~clk;

   vga_sync_monitor #(
      .H_TOTAL(HT), .H_PULSE(HP), .H_BACK(HB), .H_ACTIVE(HA),
      .V_TOTAL(VT), .V_PULSE(VP), .V_BACK(VB), .V_ACTIVE(VA),
      .HS_POL(1'b1), .VS_POL(1'b1), .EXP_RGB(12'hF00), .LOCK_FRAMES(2)
   ) dut (
      .MAX10_CLK1_50  (clk),
      .reset_n        (reset_n),
      .vga_hs         (vga_hs),
      .vga_vs         (vga_vs),
      .vga_r          (vga_r),
      .vga_g          (vga_g),
      .vga_b          (vga_b),
      .locked         (locked),
      .pix_x          (pix_x),
      .pix_y          (pix_y),
      .pix_de         (pix_de),
      .pix_rgb        (pix_rgb),
      .line_period    (line_period),
      .hs_width       (hs_width),
      .frame_lines    (frame_lines),
      .frame_err_count(frame_err_count),
      .frame_done     (frame_done)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // observations captured on the falling edge
   logic        fd_locked [16];
   logic [9:0]  fd_lines  [16];
   logic [15:0] fd_err    [16];
   logic [10:0] fd_lp     [16];
   logic [10:0] fd_hw     [16];
   logic [10:0] fd_vcnt   [16];
   int          fd_n = 0;
   int          hs5_cyc = -1;
   int          first_de_cyc = -1;
   logic [10:0] first_px;
   logic [9:0]  first_py;
   logic [11:0] first_rgb;
   logic        bad_seen = 1'b0;
   logic [10:0] bad_px;
   logic [9:0]  bad_py;
   int          lp41_cyc = -1;
   int          drop_cyc = -1;
   logic        locked_prev = 1'b0;

   // reset snapshot
   logic [2:0]  rs_bits;
   logic [10:0] rs_x, rs_lp, rs_hw;
   logic [9:0]  rs_y, rs_fl;
   logic [11:0] rs_rgb;
   logic [15:0] rs_err;

   always @(negedge clk) begin
      if (frame_done === 1'b1) begin
         if (fd_n < 16) begin
            fd_locked[fd_n] = locked;
            fd_lines[fd_n]  = frame_lines;
            fd_err[fd_n]    = frame_err_count;
            fd_lp[fd_n]     = line_period;
            fd_hw[fd_n]     = hs_width;
            fd_vcnt[fd_n]   = 11'(dut.vcnt);
         end
         fd_n = fd_n + 1;
      end
      if (pix_de === 1'b1 && first_de_cyc < 0) begin
         first_de_cyc = cyc;
         first_px     = pix_x;
         first_py     = pix_y;
         first_rgb    = pix_rgb;
      end
      if (pix_de === 1'b1 && pix_rgb === 12'h0F0 && !bad_seen) begin
         bad_seen = 1'b1;
         bad_px   = pix_x;
         bad_py   = pix_y;
      end
      if (line_period === 11'd41 && lp41_cyc < 0) lp41_cyc = cyc;
      if (locked_prev === 1'b1 && locked === 1'b0 && lp41_cyc >= 0 && drop_cyc < 0)
         drop_cyc = cyc;
      locked_prev = locked;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input int bad_y, input int long_line, input int rst_line);
      int          len;
      logic        act, bad, rst;
      logic [11:0] rgb;
      for (int l = 0; l < VT; l++) begin
         len = (l == long_line) ? HT + 1 : HT;
         for (int c = 0; c < len; c++) begin
            act = (c >= HP + HB) && (c < HP + HB + HA) && (l >= VP + VB) && (l < VP + VB + VA);
            bad = act && (l == VP + VB + bad_y) && (c >= HP + HB + BAD_X) && (c < HP + HB + BAD_X + 5);
            rgb = bad ? 12'h0F0 : (act ? 12'hF00 : 12'h000);
            vga_hs = (c < HP);
            vga_vs = (l < VP);
            {vga_r, vga_g, vga_b} = rgb;
            if (l == VP + VB && c == 0 && hs5_cyc < 0) hs5_cyc = cyc;
            rst = (l == rst_line) && (c == HP + HB + 5);
            if (rst) reset_n = 1'b0;
            tick();
            if (rst) begin
               rs_bits = {locked, pix_de, frame_done};
               rs_x    = pix_x;
               rs_y    = pix_y;
               rs_rgb  = pix_rgb;
               rs_lp   = line_period;
               rs_hw   = hs_width;
               rs_fl   = frame_lines;
               rs_err  = frame_err_count;
               reset_n = 1'b1;
            end
         end
      end
   endtask

   initial begin
      logic [12:0] exp_lock;
      logic        lat_ok;
      reset_n = 1'b0;
      vga_hs = 1'b0; vga_vs = 1'b0;
      vga_r = 4'h0; vga_g = 4'h0; vga_b = 4'h0;
      repeat (3) tick();

      // reset state
      chk("rst_locked", 32'(locked), 32'd0);
      chk("rst_pix_de", 32'(pix_de), 32'd0);
      chk("rst_pix_x", 32'(pix_x), 32'd0);
      chk("rst_pix_y", 32'(pix_y), 32'd0);
      chk("rst_pix_rgb", 32'(pix_rgb), 32'd0);
      chk("rst_line_period", 32'(line_period), 32'd0);
      chk("rst_hs_width", 32'(hs_width), 32'd0);
      chk("rst_frame_lines", 32'(frame_lines), 32'd0);
      chk("rst_frame_err", 32'(frame_err_count), 32'd0);
      chk("rst_frame_done", 32'(frame_done), 32'd0);
      reset_n = 1'b1;

      // ideal frames, one with 5 wrong pixels, one with a long line, then relock
      send_frame(-1, -1, -1);   // F0
      send_frame(-1, -1, -1);   // F1
      send_frame(4, -1, -1);    // F2: errors on active line 4, x 7..11
      send_frame(-1, -1, -1);   // F3
      send_frame(-1, 10, -1);   // F4: line 10 lasts HT+1
      send_frame(-1, -1, -1);   // F5
      send_frame(-1, -1, -1);   // F6
      send_frame(-1, -1, -1);   // F7

      // HS lost for 2100 clocks
      vga_hs = 1'b0; vga_vs = 1'b0;
      {vga_r, vga_g, vga_b} = 12'h000;
      repeat (2100) tick();
      chk("hs_lost_hcnt", 32'(dut.hcnt), 32'd2047);
      chk("hs_lost_locked", 32'(locked), 32'd0);

      send_frame(-1, -1, -1);   // F8
      send_frame(-1, -1, 8);    // F9: reset pulse mid-active region
      send_frame(-1, -1, -1);   // F10
      send_frame(-1, -1, -1);   // F11
      send_frame(-1, -1, -1);   // F12
      vga_hs = 1'b0; vga_vs = 1'b0;
      repeat (10) tick();

      // first active pixel after reset
      chk("first_de_latency", 32'(first_de_cyc - hs5_cyc), 32'(3 + HP + HB));
      chk("first_de_x", 32'(first_px), 32'd0);
      chk("first_de_y", 32'(first_py), 32'd0);
      chk("first_de_rgb", 32'(first_rgb), 32'hF00);

      // frame results
      chk("frame_done_count", 32'(fd_n), 32'd13);
      chk("f0_frame_lines", 32'(fd_lines[1]), 32'(VT));
      chk("f0_vcnt_at_vs", 32'(fd_vcnt[1]), 32'd0);
      chk("f1_line_period", 32'(fd_lp[2]), 32'(HT));
      chk("f1_hs_width", 32'(fd_hw[2]), 32'(HP));
      chk("f1_frame_err", 32'(fd_err[2]), 32'd0);
      chk("f2_frame_err", 32'(fd_err[3]), 32'd5);
      chk("f3_frame_err", 32'(fd_err[4]), 32'd0);
      chk("f11_frame_lines", 32'(fd_lines[12]), 32'(VT));
      chk("bad_pixel_seen", 32'(bad_seen), 32'd1);
      chk("bad_pixel_x", 32'(bad_px), 32'(BAD_X));
      chk("bad_pixel_y", 32'(bad_py), 32'd4);

      // lock state at each VS leading edge, index 0 first
      exp_lock = 13'b1_0000_1001_1100;
      for (int i = 0; i < 13; i++)
         chk($sformatf("lock_at_vs%0d", i), 32'(fd_locked[i]), 32'(exp_lock[i]));

      // long line drops lock promptly
      chk("long_line_seen", 32'(lp41_cyc >= 0), 32'd1);
      lat_ok = (drop_cyc >= lp41_cyc) && (drop_cyc - lp41_cyc <= 2) && (lp41_cyc >= 0);
      chk("long_line_drop", 32'(lat_ok), 32'd1);

      // outputs right after mid-frame reset
      chk("midrst_bits", 32'(rs_bits), 32'd0);
      chk("midrst_pix_x", 32'(rs_x), 32'd0);
      chk("midrst_pix_y", 32'(rs_y), 32'd0);
      chk("midrst_pix_rgb", 32'(rs_rgb), 32'd0);
      chk("midrst_line_period", 32'(rs_lp), 32'd0);
      chk("midrst_hs_width", 32'(rs_hw), 32'd0);
      chk("midrst_frame_lines", 32'(rs_fl), 32'd0);
      chk("midrst_frame_err", 32'(rs_err), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
